// File: rtl/ram8_16_pkg.sv
// Shared word/address constants, bus types and gate-level helper functions
// for the RAM8 tier; reused unchanged by RAM64/RAM512.
package ram8_16_pkg;

    localparam int unsigned WORD_W        = 16;
    localparam int unsigned RAM8_ADDR_W   = 3;
    localparam int unsigned RAM8_DEPTH    = 8;
    localparam logic [WORD_W-1:0] RAM_RESET_VAL = 16'h0000;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [RAM8_ADDR_W-1:0] addr_t;
    typedef word_t [RAM8_DEPTH-1:0] word_bank_t;

    // Write-port payload as seen by the decode stage.
    typedef struct packed {
        logic  load;
        addr_t address;
        word_t data;
    } wr_req_t;

    // 2-to-1 mux gate: sel=0 -> a, sel=1 -> b.
    function automatic logic mux2(input logic a, input logic b, input logic sel);
        return sel ? b : a;
    endfunction

    // 1-to-8 demux; {sel[2],sel[1],sel[0]} = {sel_1,sel_2,sel_3}, bit 0 is output a.
    function automatic logic [RAM8_DEPTH-1:0] dmux8way(input logic in_b, input addr_t sel);
        logic [RAM8_DEPTH-1:0] o;
        o = '0;
        for (int unsigned i = 0; i < RAM8_DEPTH; i++) begin
            o[i] = in_b & (sel == RAM8_ADDR_W'(i));
        end
        return o;
    endfunction

    // 8-way 16-bit mux as a three-level tree, sel[0] resolved first.
    function automatic word_t mux8way16(input word_bank_t w, input addr_t sel);
        word_t l1 [4];
        word_t l2 [2];
        for (int unsigned i = 0; i < 4; i++) begin
            l1[i] = sel[0] ? w[2*i+1] : w[2*i];
        end
        for (int unsigned i = 0; i < 2; i++) begin
            l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
        end
        return sel[2] ? l2[1] : l2[0];
    endfunction

endpackage

// File: rtl/ram8_16_reg16_load.sv
// 16-bit load register: one DFF-with-load cell per bit, feedback through the
// 2-to-1 mux gate; asynchronous active-low reset to RESET_VAL.
module reg16_load
    import ram8_16_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = RAM_RESET_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    output logic [WORD_W-1:0] out
);

    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
        logic bit_d;
        logic bit_q;

        always_comb begin
            bit_d = mux2(bit_q, in[i], load);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bit_q <= RESET_VAL[i];
            end else begin
                bit_q <= bit_d;
            end
        end

        assign out[i] = bit_q;
    end

endmodule

// File: rtl/ram8_16.sv
// 8 x 16-bit register-file RAM: demux-decoded writes, combinational 8-way read.
// Optional write-through view of `in` on `out` when RAM8_16_BYPASS_EN is defined.
module ram8_16
    import ram8_16_pkg::*;
#(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);

    // The demux/mux datapath is fixed at 16 bits.
    if (WIDTH != WORD_W) begin : g_width_chk
        $error("ram8_16: WIDTH must be %0d", WORD_W);
    end

    wr_req_t               wr_req;
    logic                  addr_known;
    logic [RAM8_DEPTH-1:0] load_vec;
    word_bank_t            words;
    word_t                 rd_word;

    // Gate load on a known address so X/Z addresses never write in simulation.
    always_comb begin
        addr_known = 1'b1;
`ifndef SYNTHESIS
        addr_known = !$isunknown(address);
`endif
        wr_req.load    = load & addr_known;
        wr_req.address = address;
        wr_req.data    = WORD_W'(in);
        load_vec       = dmux8way(wr_req.load, wr_req.address);
    end

    for (genvar w = 0; w < RAM8_DEPTH; w++) begin : g_word
        reg16_load #(
            .RESET_VAL (WORD_W'(RESET_VAL))
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (wr_req.data),
            .load  (load_vec[w]),
            .out   (words[w])
        );
    end

    always_comb begin
        rd_word = mux8way16(words, address);
    end

`ifdef RAM8_16_BYPASS_EN
    // Write-through forwarding; suppressed during reset so out stays at RESET_VAL.
    always_comb begin
        out = WIDTH'(rd_word);
        if (load && rst_n) begin
            out = in;
        end
    end
`else
    always_comb begin
        out = WIDTH'(rd_word);
    end
`endif

endmodule

// File: tb/tb_ram8_16.sv
// Scoreboard bench for ram8_16: stimulus queues expected read data per cycle,
// a negedge monitor pops and compares against out.
module tb_ram8_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       total;
    int       bad;
    bit       stim_done;

    ram8_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: everything queued during a cycle is checked at the following negedge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            total++;
            if (out !== it.exp) begin
                bad++;
                $display("FAIL %s: out=%h expected=%h (addr=%0d t=%0t)", it.tag, out, it.exp, address, $time);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [2:0] a, input logic [15:0] d);
        load    = ld;
        address = a;
        in      = d;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] e);
        sb_item_t it;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time=%0t expected=stim_done", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pre_exp;
        total = 0;
        bad = 0;
        stim_done = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0000);

        // 1: reset then sweep
        cyc();
        expect_out("rst_low", 16'h0000);
        cyc();
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            cyc();
            drive(1'b0, 3'(a), 16'hA5A5);
            expect_out($sformatf("reset_sweep_%0d", a), 16'h0000);
        end

        // 2: two writes, no aliasing
        cyc(); drive(1'b1, 3'd3, 16'hBEEF);
        cyc(); drive(1'b1, 3'd7, 16'h1234);
        for (int a = 0; a < 8; a++) begin
            cyc();
            drive(1'b0, 3'(a), 16'h0000);
            expect_out($sformatf("alias_%0d", a),
                       (a == 3) ? 16'hBEEF : (a == 7) ? 16'h1234 : 16'h0000);
        end

        // 3: read during write at address 5
        cyc(); drive(1'b1, 3'd5, 16'h00AA);
        cyc(); drive(1'b0, 3'd5, 16'h0000);
        expect_out("rdw_init", 16'h00AA);
`ifdef RAM8_16_BYPASS_EN
        pre_exp = 16'h5555;
`else
        pre_exp = 16'h00AA;
`endif
        cyc(); drive(1'b1, 3'd5, 16'h5555);
        expect_out("rdw_before_edge", pre_exp);
        cyc(); drive(1'b0, 3'd5, 16'h0000);
        expect_out("rdw_after_edge", 16'h5555);

        // 4: fill with FFFF, async reset mid-cycle while load=1
        for (int a = 0; a < 8; a++) begin
            cyc();
            drive(1'b1, 3'(a), 16'hFFFF);
        end
        cyc(); drive(1'b0, 3'd0, 16'h0000);
        expect_out("fill_ffff", 16'hFFFF);
        cyc(); drive(1'b1, 3'd4, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        expect_out("async_reset", 16'h0000);
        cyc();
        expect_out("reset_wins", 16'h0000);
        cyc();
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            cyc();
            drive(1'b0, 3'(a), 16'h0000);
            expect_out($sformatf("post_reset_%0d", a), 16'h0000);
        end

        // 5: load=0 holds
        cyc(); drive(1'b1, 3'd2, 16'h0F0F);
        for (int k = 0; k < 4; k++) begin
            cyc();
            drive(1'b0, 3'd2, 16'hDEAD);
            expect_out($sformatf("hold_%0d", k), 16'h0F0F);
        end

        // 6: write i*1111, read back in reverse
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(1'b1, 3'(i), 16'(i * 16'h1111));
        end
        for (int i = 7; i >= 0; i--) begin
            cyc();
            drive(1'b0, 3'(i), 16'h0000);
            expect_out($sformatf("reverse_%0d", i), 16'(i * 16'h1111));
        end

        // Same-cycle address change: second lookup within one cycle
        cyc(); drive(1'b0, 3'd6, 16'h0000);
        #1;
        address = 3'd1;
        expect_out("addr_change_same_cycle", 16'h1111);

        cyc();
        cyc();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
